inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 32: width of the write address.
REQ-003 SHALL have parameter NUM_WORDS, default 128: instruction memory depth in words.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as the two ports below.
REQ-005 SHALL have port cpu_clk  in  1  clock for all state.
REQ-006 SHALL have port cpu_rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a load.
REQ-008 SHALL have port byte_in_data  in  8  incoming program byte.
REQ-009 SHALL have port byte_in_valid  in  1  byte_in_data is valid.
REQ-010 SHALL have port byte_in_ready  out  1  loader accepts the byte.
REQ-011 SHALL have port dma_inst_mem_waddr  out  INST_ADDR_WIDTH  word index, not a byte address.
REQ-012 SHALL have port dma_inst_mem_wdata  out  INST_WIDTH  assembled instruction word.
REQ-013 SHALL have port inst_mem_write  out  1  single-cycle write strobe.
REQ-014 SHALL have port load_busy  out  1  high while a load runs; holds the CPU.
REQ-015 SHALL have port load_done  out  1  sticky: last load completed.
REQ-016 SHALL have port load_err  out  1  sticky: last load rejected its length.

Function
REQ-017 SHALL implement states IDLE, LEN, DATA, DONE.
REQ-018 SHALL complete a byte handshake in every cycle where byte_in_valid and byte_in_ready are both high.
REQ-019 SHALL hold byte_in_ready high in LEN and DATA, and low in IDLE and DONE.
REQ-020 In IDLE, start SHALL do all of: clear load_done and load_err, clear the byte and word counters, and move to LEN on the next edge.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 In LEN, the loader SHALL take 4 bytes little-endian, first byte to bits [7:0], forming length L.
REQ-023 If L==0 or L>NUM_WORDS after the 4th LEN byte, the loader SHALL set load_err=1, write nothing, and return to IDLE.
REQ-024 If L is valid, the loader SHALL latch L and enter DATA.
REQ-025 In DATA, the loader SHALL assemble each group of 4 bytes little-endian into one word.
REQ-026 On the edge after the 4th byte handshake, the loader SHALL do all of: assert inst_mem_write for exactly one cycle, drive waddr = word counter and the assembled wdata, and increment the word counter.
REQ-027 On the 4th byte of word L-1, the loader SHALL move to DATA→DONE; that word's write strobe coincides with the DONE cycle.
REQ-028 DONE SHALL last exactly one cycle, then set load_done=1 and go to IDLE.
REQ-029 The byte counter SHALL be 2 bits and wrap 3→0.
REQ-030 The word counter SHALL be wide enough for NUM_WORDS, saturating at NUM_WORDS.
REQ-031 Write latency from the 4th byte handshake to inst_mem_write SHALL be 1 cycle, and waddr/wdata SHALL stay stable while the strobe is high.
REQ-032 load_busy SHALL be high in LEN, DATA and DONE, and low in IDLE.
REQ-033 Gaps in byte_in_valid SHALL stall assembly without loss, and there SHALL be no timeout.
REQ-034 Back-to-back bytes at one per cycle SHALL be sustained with no dropped bytes.

Reset
REQ-035 While cpu_rst is high at a clock edge: state=IDLE; all counters 0; inst_mem_write=0; byte_in_ready=0; load_busy=0; load_done=0; load_err=0; waddr=0; wdata=0.
REQ-036 A reset mid-load SHALL abort the load with no further writes; words already written stay in memory.
REQ-037 If cpu_rst and start are high in the same cycle, reset SHALL win.

Structure
REQ-038 The state enum, byte width (8) and bytes-per-word (4) SHALL live in shared package inst_loader_pkg.
REQ-039 Byte-to-word assembly (shift register plus 2-bit counter, emitting a word-valid pulse) SHALL be sub-module word_assembler, reused by LEN and DATA.

Verification
REQ-040 The bench SHALL cover: start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 at one per cycle -> two write strobes, (waddr 0, wdata 0x00000013) then (waddr 1, wdata 0x00100093); load_done=1; load_busy=0.
REQ-041 The bench SHALL cover: length bytes 00 00 00 00 -> load_err=1, no inst_mem_write, IDLE.
REQ-042 The bench SHALL cover: length 0x81 with NUM_WORDS=128 -> load_err=1, no write; length 0x80 is accepted.
REQ-043 The bench SHALL cover: valid toggling 1/0 every cycle during a 1-word load -> same wdata as continuous streaming, with the write 1 cycle after the 4th accepted byte.
REQ-044 The bench SHALL cover: cpu_rst pulsed after 6 payload bytes of a 3-word load -> exactly 1 write observed, then all outputs 0 and byte_in_ready=0.
REQ-045 The bench SHALL cover: start pulsed during DATA -> ignored; counters unchanged; the load completes normally.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e         : loader FSM states
//   BYTE_W          : width of one incoming program byte
//   BYTES_PER_WORD  : bytes assembled into one 32-bit word (little-endian)
//   WORD_W          : width of an assembled word
//   BYTE_CNT_W      : width of the byte-in-word counter
package inst_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Collects bytes little-endian into 32-bit words. The first byte of a group
// lands in bits [7:0]. When the fourth byte is accepted, word_o carries the
// complete word and word_valid_o pulses in that same cycle.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   clear_i      : restart the byte count (start of a new load)
//   byte_valid_i : a byte handshake completes this cycle
//   byte_i       : the byte being accepted
//   word_o       : assembled word (valid only while word_valid_o is high)
//   word_valid_o : fourth byte of a group accepted this cycle
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int SHIFT_W = WORD_W - BYTE_W;

  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  // The three earlier bytes sit in the shift register; the fourth is taken
  // straight from the input so the word is ready in the handshake cycle.
  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      // New bytes enter at the top so the oldest ends up in the low byte.
      shift_d = {byte_i, shift_q[SHIFT_W-1:BYTE_W]};
      cnt_d   = cnt_q + BYTE_CNT_W'(1);  // wraps 3 -> 0
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a program into instruction memory from a byte stream.
// A load starts with a 4-byte little-endian word count L, followed by L
// little-endian 32-bit words. Each word is written with a one-cycle strobe
// at word index 0..L-1. A zero or oversized count aborts with load_err.
//   cpu_clk, cpu_rst      : clock and synchronous active-high reset
//   start                 : pulse in IDLE to begin a load
//   byte_in_data/valid    : incoming byte stream
//   byte_in_ready         : high while the loader takes bytes (LEN, DATA)
//   dma_inst_mem_waddr    : word index of the write
//   dma_inst_mem_wdata    : assembled instruction word
//   inst_mem_write        : one-cycle write strobe
//   load_busy             : load in progress (holds the CPU)
//   load_done / load_err  : sticky status of the last load
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       start,
  input  logic [7:0]                 byte_in_data,
  input  logic                       byte_in_valid,
  output logic                       byte_in_ready,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err
);

  // Wide enough to hold NUM_WORDS itself, where the word counter saturates.
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           len_q, len_d;
  logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
  logic                       write_q, write_d;
  logic [INST_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [INST_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       byte_fire;
  logic                       load_start;
  logic [WORD_W-1:0]          asm_word;
  logic                       asm_word_valid;
  logic                       len_bad;

  assign byte_in_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign load_busy     = (state_q != ST_IDLE);
  assign byte_fire     = byte_in_valid && byte_in_ready;
  assign load_start    = (state_q == ST_IDLE) && start;
  assign len_bad       = (asm_word == '0) || (asm_word > WORD_W'(NUM_WORDS));

  // One assembler serves both phases: the length field and every data word.
  word_assembler u_word_assembler (
    .clk_i        (cpu_clk),
    .rst_i        (cpu_rst),
    .clear_i      (load_start),
    .byte_valid_i (byte_fire),
    .byte_i       (byte_in_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  // NOTE: every variable gets its default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    write_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_cnt_d = '0;
          state_d    = ST_LEN;
        end
      end

      ST_LEN: begin
        if (asm_word_valid) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d   = CNT_W'(asm_word);
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (asm_word_valid) begin
          // Address and data are registered with the strobe, so they are
          // stable for the whole strobe cycle.
          write_d = 1'b1;
          waddr_d = INST_ADDR_WIDTH'(word_cnt_q);
          wdata_d = INST_WIDTH'(asm_word);
          if (word_cnt_q != CNT_W'(NUM_WORDS)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (word_cnt_q == len_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      write_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign inst_mem_write     = write_q;
  assign dma_inst_mem_waddr = waddr_q;
  assign dma_inst_mem_wdata = wdata_q;
  assign load_done          = done_q;
  assign load_err           = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader. A reference model turns each byte
// stream into the list of memory writes it should cause; those go into a
// scoreboard queue that a negedge monitor drains whenever a strobe appears.
module tb_inst_mem_loader;

  localparam int NW = 128;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        start;
  logic [7:0]  byte_in_data;
  logic        byte_in_valid;
  logic        byte_in_ready;
  logic [31:0] dma_inst_mem_waddr;
  logic [31:0] dma_inst_mem_wdata;
  logic        inst_mem_write;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  inst_mem_loader #(
    .INST_WIDTH      (32),
    .INST_ADDR_WIDTH (32),
    .NUM_WORDS       (NW)
  ) dut (
    .cpu_clk            (cpu_clk),
    .cpu_rst            (cpu_rst),
    .start              (start),
    .byte_in_data       (byte_in_data),
    .byte_in_valid      (byte_in_valid),
    .byte_in_ready      (byte_in_ready),
    .dma_inst_mem_waddr (dma_inst_mem_waddr),
    .dma_inst_mem_wdata (dma_inst_mem_wdata),
    .inst_mem_write     (inst_mem_write),
    .load_busy          (load_busy),
    .load_done          (load_done),
    .load_err           (load_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         hs_cnt = 0;
  bit         len_ok = 1'b0;
  bit         pend_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: length is the first four bytes little-endian; word i is
  // bytes 4+4i .. 7+4i little-endian. Only words fully sent are expected.
  task automatic build_expect(input int n_sent);
    int unsigned l;
    l = {stim[3], stim[2], stim[1], stim[0]};
    len_ok = (l != 0) && (l <= NW);
    if (len_ok) begin
      for (int i = 0; i < int'(l); i++) begin
        if (4 * i + 7 < n_sent)
          exp_q.push_back('{addr: 32'(i),
                            data: {stim[4*i+7], stim[4*i+6], stim[4*i+5], stim[4*i+4]}});
      end
    end
  endtask

  task automatic fill_stim(input logic [31:0] l, input int nwords);
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(l[8*i +: 8]);
    for (int i = 0; i < 4 * nwords; i++) stim.push_back(8'($urandom));
  endtask

  // Monitor: a write is due one cycle after each completed data word; every
  // strobe pops one scoreboard entry.
  always @(negedge cpu_clk) begin
    bit exp_wr;
    wr_t e;
    exp_wr  = pend_wr;
    pend_wr = 1'b0;
    if (exp_wr || inst_mem_write) check("wr_strobe", 64'(inst_mem_write), 64'(exp_wr));
    if (inst_mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 dma_inst_mem_waddr, dma_inst_mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(dma_inst_mem_waddr), 64'(e.addr));
        check("wr_data", 64'(dma_inst_mem_wdata), 64'(e.data));
      end
    end
    if (byte_in_valid && byte_in_ready && !cpu_rst) begin
      hs_cnt++;
      if (len_ok && hs_cnt > 4 && ((hs_cnt - 4) % 4) == 0) pend_wr = 1'b1;
    end
  end

  // Drive the first n_send bytes of stim after a start pulse.
  // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random gaps.
  // start_at: byte index whose handshake cycle also carries a stray start.
  task automatic drive_load(input int n_send, input int gap_mode, input int start_at);
    int budget;
    build_expect(n_send);
    hs_cnt = 0;
    @(posedge cpu_clk); #1;
    start = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      byte_in_valid = 1'b1;
      byte_in_data  = stim[i];
      start         = (i == start_at);
      budget = 0;
      @(negedge cpu_clk);
      while (!byte_in_ready && budget < 20) begin
        budget++;
        @(negedge cpu_clk);
      end
      if (!byte_in_ready) begin
        check("ready_timeout", 64'(byte_in_ready), 64'(1));
        byte_in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge cpu_clk); #1;
      byte_in_valid = 1'b0;
      start         = 1'b0;
      if (gap_mode == 1) begin
        @(posedge cpu_clk); #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge cpu_clk); #1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge cpu_clk);
    while (load_busy && b < 50) begin
      b++;
      @(negedge cpu_clk);
    end
    check("busy_end", 64'(load_busy), 64'(0));
  endtask

  task automatic finish_load(input bit exp_err);
    wait_idle();
    check("load_done", 64'(load_done), 64'(!exp_err));
    check("load_err", 64'(load_err), 64'(exp_err));
    check("ready_idle", 64'(byte_in_ready), 64'(0));
    check("sb_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(load_busy), 64'(0));
    check({tag, "_done"}, 64'(load_done), 64'(0));
    check({tag, "_err"}, 64'(load_err), 64'(0));
    check({tag, "_write"}, 64'(inst_mem_write), 64'(0));
    check({tag, "_ready"}, 64'(byte_in_ready), 64'(0));
    check({tag, "_waddr"}, 64'(dma_inst_mem_waddr), 64'(0));
    check({tag, "_wdata"}, 64'(dma_inst_mem_wdata), 64'(0));
  endtask

  initial begin
    logic [31:0] l;
    int nw;
    cpu_rst       = 1'b1;
    start         = 1'b0;
    byte_in_valid = 1'b0;
    byte_in_data  = '0;
    repeat (3) @(posedge cpu_clk);
    #1 cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check_all_zero("reset");

    // Two-word program streamed one byte per cycle.
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    drive_load(12, 0, -1);
    finish_load(1'b0);

    // Zero length.
    fill_stim(32'd0, 0);
    drive_load(4, 0, -1);
    finish_load(1'b1);

    // One past the memory depth, then exactly the depth.
    fill_stim(32'h81, 0);
    drive_load(4, 0, -1);
    finish_load(1'b1);
    fill_stim(32'h80, NW);
    drive_load(4 + 4 * NW, 0, -1);
    finish_load(1'b0);

    // Same one-word program, continuous and with valid toggling.
    fill_stim(32'd1, 1);
    drive_load(8, 0, -1);
    finish_load(1'b0);
    drive_load(8, 1, -1);
    finish_load(1'b0);

    // Reset after six payload bytes of a three-word load.
    fill_stim(32'd3, 3);
    drive_load(10, 0, -1);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check_all_zero("midrst");
    repeat (5) @(negedge cpu_clk);
    check("midrst_sb", 64'(exp_q.size()), 64'(0));

    // Stray start pulses during LEN-to-DATA and mid-DATA are ignored.
    fill_stim(32'd3, 3);
    drive_load(16, 0, 6);
    finish_load(1'b0);
    drive_load(16, 2, 4);
    finish_load(1'b0);

    // Reset and start together: reset wins.
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    start   = 1'b1;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    start   = 1'b0;
    @(negedge cpu_clk);
    check_all_zero("rst_start");

    // Randomized loads, some with rejected lengths.
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       l = 32'(NW + 1 + $urandom_range(0, 200));
        1:       l = {8'($urandom_range(1, 255)), 24'($urandom_range(1, 5))};
        default: l = 32'($urandom_range(1, 6));
      endcase
      nw = (l >= 1 && l <= NW) ? int'(l) : 0;
      fill_stim(l, nw);
      drive_load(4 + 4 * nw, int'($urandom_range(0, 2)), -1);
      finish_load(nw == 0);
    end

    repeat (3) @(negedge cpu_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
